aes_round_ctrl: RTL and testbench

Parametrised AES round sequencer; next generation of the fixed 10-round cipher state machine. Supports AES-128/192/256 round counts (10/12/14) selected per block, with a Start/Busy/Done handshake, pipeline stall and first/last-round qualifiers. Drives round-key select and datapath muxing for the cipher core.

---
 rtl/aes_round_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_aes_round_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: AES round sequencer for 10/12/14-round key schedules.
// Start/Busy/Done handshake, stall freeze and first/last-round qualifiers.
// All outputs are registered. Reset is synchronous and active-high.
// Optional feature macro: AES_CTRL_DECRYPT_EN. When it is defined, a Decrypt
// input is added, and the round index counts down from Nr to 0.
module aes_round_ctrl #(
    parameter int NR_128  = 10,
    parameter int NR_192  = 12,
    parameter int NR_256  = 14,
    parameter int ROUND_W = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Start,
    input  logic [1:0]         Key_Size,
    input  logic               Stall,
`ifdef AES_CTRL_DECRYPT_EN
    input  logic               Decrypt,
`endif
    output logic               Busy,
    output logic               Done,
    output logic [ROUND_W-1:0] Round_Num,
    output logic               First_Round,
    output logic               Last_Round,
    output logic               Key_Err
);

    localparam logic [ROUND_W-1:0] ROUND_ZERO = {ROUND_W{1'b0}};
    localparam logic [ROUND_W-1:0] ROUND_ONE  = {{(ROUND_W-1){1'b0}}, 1'b1};
    localparam logic [ROUND_W-1:0] NR_128_W   = ROUND_W'(NR_128);
    localparam logic [ROUND_W-1:0] NR_192_W   = ROUND_W'(NR_192);
    localparam logic [ROUND_W-1:0] NR_256_W   = ROUND_W'(NR_256);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // The reserved key size falls back to the AES-128 round count.
    function automatic logic [ROUND_W-1:0] nr_decode(input logic [1:0] key_size);
        logic [ROUND_W-1:0] nr;
        case (key_size)
            2'b00:   nr = NR_128_W;
            2'b01:   nr = NR_192_W;
            2'b10:   nr = NR_256_W;
            default: nr = NR_128_W;
        endcase
        return nr;
    endfunction

    state_t             state_r, state_nxt_s;
    logic [ROUND_W-1:0] nr_r, nr_nxt_s, nr_start_s;
    logic               dec_r, dec_nxt_s, start_dec_s;
    logic               busy_nxt_s, done_nxt_s, first_nxt_s, last_nxt_s, kerr_nxt_s;
    logic [ROUND_W-1:0] round_nxt_s, round_step_s, end_round_s;
    logic               at_end_s, bad_s;

`ifdef AES_CTRL_DECRYPT_EN
    assign start_dec_s = Decrypt;
`else
    assign start_dec_s = 1'b0;
`endif

    assign nr_start_s = nr_decode(Key_Size);

    // Round stepping direction and terminal index depend on the latched mode.
    always_comb begin
        round_step_s = Round_Num + ROUND_ONE;
        end_round_s  = nr_r;
        if (dec_r) begin
            round_step_s = Round_Num - ROUND_ONE;
            end_round_s  = ROUND_ZERO;
        end else begin
            round_step_s = Round_Num + ROUND_ONE;
            end_round_s  = nr_r;
        end
        at_end_s = (Round_Num == end_round_s);
        bad_s    = (Round_Num > nr_r);
    end

    // State register and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= IDLE;
            nr_r        <= NR_128_W;
            dec_r       <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Round_Num   <= ROUND_ZERO;
            First_Round <= 1'b0;
            Last_Round  <= 1'b0;
            Key_Err     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            nr_r        <= nr_nxt_s;
            dec_r       <= dec_nxt_s;
            Busy        <= busy_nxt_s;
            Done        <= done_nxt_s;
            Round_Num   <= round_nxt_s;
            First_Round <= first_nxt_s;
            Last_Round  <= last_nxt_s;
            Key_Err     <= kerr_nxt_s;
        end
    end

    // Next-state decision. An out-of-range round index recovers to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (Start) state_nxt_s = RUN;
                else       state_nxt_s = IDLE;
            end
            RUN: begin
                if (bad_s)         state_nxt_s = IDLE;
                else if (Stall)    state_nxt_s = RUN;
                else if (at_end_s) state_nxt_s = IDLE;
                else               state_nxt_s = RUN;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values of the registered outputs and the per-block latches.
    always_comb begin
        nr_nxt_s    = nr_r;
        dec_nxt_s   = dec_r;
        busy_nxt_s  = Busy;
        done_nxt_s  = 1'b0;
        round_nxt_s = Round_Num;
        first_nxt_s = First_Round;
        last_nxt_s  = Last_Round;
        kerr_nxt_s  = Key_Err;
        case (state_r)
            IDLE: begin
                if (Start) begin
                    nr_nxt_s    = nr_start_s;
                    dec_nxt_s   = start_dec_s;
                    kerr_nxt_s  = (Key_Size == 2'b11);
                    busy_nxt_s  = 1'b1;
                    round_nxt_s = start_dec_s ? nr_start_s : ROUND_ZERO;
                    first_nxt_s = 1'b1;
                    last_nxt_s  = 1'b0;
                end else begin
                    busy_nxt_s  = 1'b0;
                    round_nxt_s = ROUND_ZERO;
                    first_nxt_s = 1'b0;
                    last_nxt_s  = 1'b0;
                end
            end
            RUN: begin
                if (bad_s) begin
                    busy_nxt_s  = 1'b0;
                    round_nxt_s = ROUND_ZERO;
                    first_nxt_s = 1'b0;
                    last_nxt_s  = 1'b0;
                    kerr_nxt_s  = 1'b0;
                end else if (Stall) begin
                    busy_nxt_s  = Busy;
                    round_nxt_s = Round_Num;
                end else if (at_end_s) begin
                    busy_nxt_s  = 1'b0;
                    done_nxt_s  = 1'b1;
                    round_nxt_s = ROUND_ZERO;
                    first_nxt_s = 1'b0;
                    last_nxt_s  = 1'b0;
                end else begin
                    round_nxt_s = round_step_s;
                    first_nxt_s = 1'b0;
                    last_nxt_s  = (round_step_s == end_round_s);
                end
            end
            default: begin
                busy_nxt_s  = 1'b0;
                round_nxt_s = ROUND_ZERO;
                first_nxt_s = 1'b0;
                last_nxt_s  = 1'b0;
                kerr_nxt_s  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl. Stimulus pushes one expected block
// record per accepted Start. The monitor pops a record at every Done pulse.
module tb_aes_round_ctrl;

    logic       CLK = 1'b0;
    logic       RST, Start, Stall;
    logic [1:0] Key_Size;
`ifdef AES_CTRL_DECRYPT_EN
    logic       Decrypt;
`endif
    logic       Busy, Done, First_Round, Last_Round, Key_Err;
    logic [3:0] Round_Num;

    always #5 CLK = ~CLK;

    aes_round_ctrl dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Key_Size(Key_Size), .Stall(Stall),
`ifdef AES_CTRL_DECRYPT_EN
        .Decrypt(Decrypt),
`endif
        .Busy(Busy), .Done(Done), .Round_Num(Round_Num),
        .First_Round(First_Round), .Last_Round(Last_Round), .Key_Err(Key_Err)
    );

    typedef struct {
        int start_cyc;
        int lat;
        int kerr;
        int first_at;
        int last_at;
        int busy_cyc;
    } exp_t;

    exp_t sb[$];
    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int n_done = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Monitor: track qualifiers during a block and score each Done pulse.
    initial begin : monitor
        int   mon_busy;
        int   mon_first;
        int   mon_last;
        exp_t e;
        mon_busy = 0; mon_first = -1; mon_last = -1;
        forever begin
            @(negedge CLK);
            if (RST === 1'b1) begin
                mon_busy = 0; mon_first = -1; mon_last = -1;
            end else begin
                if (Busy === 1'b1) mon_busy++;
                if (First_Round === 1'b1) mon_first = int'(Round_Num);
                if (Last_Round === 1'b1) mon_last = int'(Round_Num);
                if (Done === 1'b1) begin
                    n_done++;
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("done_latency", cyc - e.start_cyc, e.lat);
                        chk("key_err", int'(Key_Err), e.kerr);
                        chk("first_round_at", mon_first, e.first_at);
                        chk("last_round_at", mon_last, e.last_at);
                        chk("busy_cycles", mon_busy, e.busy_cyc);
                        chk("busy_in_done", int'(Busy), 0);
                        chk("round_in_done", int'(Round_Num), 0);
                    end
                    mon_busy = 0; mon_first = -1; mon_last = -1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input int sc, input int nr, input int kerr, input logic dec,
                            input int stalls);
        exp_t e;
        e.start_cyc = sc;
        e.lat       = nr + 2 + stalls;
        e.kerr      = kerr;
        e.first_at  = dec ? nr : 0;
        e.last_at   = dec ? 0 : nr;
        e.busy_cyc  = nr + 1 + stalls;
        sb.push_back(e);
    endtask

    task automatic start_block(input logic [1:0] ks, input logic dec, input int nr,
                               input int kerr, input int stalls, input bit expect_done);
        Key_Size = ks;
`ifdef AES_CTRL_DECRYPT_EN
        Decrypt = dec;
`endif
        Start = 1'b1;
        if (expect_done) push_exp(cyc, nr, kerr, dec, stalls);
        tick();
        Start = 1'b0;
        chk("busy_after_start", int'(Busy), 1);
        chk("round_after_start", int'(Round_Num), dec ? nr : 0);
        chk("first_after_start", int'(First_Round), 1);
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (n_done < target && t < 80) begin
            tick();
            t++;
        end
        chk("done_seen", int'(n_done >= target), 1);
    endtask

    task automatic wait_round(input int r);
        int t;
        t = 0;
        while (int'(Round_Num) != r && t < 20) begin
            tick();
            t++;
        end
        chk("reach_round", int'(Round_Num), r);
    endtask

    task automatic chk_reset_outs();
        chk("rst_busy", int'(Busy), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_round", int'(Round_Num), 0);
        chk("rst_first", int'(First_Round), 0);
        chk("rst_last", int'(Last_Round), 0);
        chk("rst_kerr", int'(Key_Err), 0);
    endtask

    initial begin
        int s0;
        RST = 1'b1; Start = 1'b0; Stall = 1'b0; Key_Size = 2'b00;
`ifdef AES_CTRL_DECRYPT_EN
        Decrypt = 1'b0;
`endif
        tick(); tick();
        RST = 1'b0;
        chk_reset_outs();

        // AES-128 with a mid-block Start pulse and Key_Size change, both ignored.
        start_block(2'b00, 1'b0, 10, 0, 0, 1'b1);
        tick(); tick();
        Key_Size = 2'b10; Start = 1'b1;
        tick();
        Start = 1'b0;
        wait_done(1);

        // AES-192 and AES-256.
        start_block(2'b01, 1'b0, 12, 0, 0, 1'b1);
        wait_done(2);
        start_block(2'b10, 1'b0, 14, 0, 0, 1'b1);
        wait_done(3);

        // Start held high: three back-to-back AES-128 blocks, 12 cycles apart.
        Key_Size = 2'b00; Start = 1'b1;
        s0 = cyc;
        push_exp(s0, 10, 0, 1'b0, 0);
        push_exp(s0 + 12, 10, 0, 1'b0, 0);
        push_exp(s0 + 24, 10, 0, 1'b0, 0);
        repeat (25) tick();
        Start = 1'b0;
        wait_done(6);

        // Three stall cycles at round 5.
        start_block(2'b00, 1'b0, 10, 0, 3, 1'b1);
        wait_round(5);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_round_hold", int'(Round_Num), 5);
            chk("stall_no_done", int'(Done), 0);
        end
        Stall = 1'b0;
        wait_done(7);

        // Reset at round 7 aborts the block with no Done; a fresh block runs fully.
        start_block(2'b00, 1'b0, 10, 0, 0, 1'b0);
        wait_round(7);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk_reset_outs();
        repeat (15) tick();
        chk("abort_no_done", n_done, 7);
        start_block(2'b00, 1'b0, 10, 0, 0, 1'b1);
        wait_done(8);

        // Reserved key size: 10 rounds with Key_Err held until the next Start.
        start_block(2'b11, 1'b0, 10, 1, 0, 1'b1);
        wait_done(9);
        tick(); tick();
        chk("kerr_hold_idle", int'(Key_Err), 1);
        start_block(2'b00, 1'b0, 10, 0, 0, 1'b1);
        chk("kerr_cleared", int'(Key_Err), 0);
        wait_done(10);

`ifdef AES_CTRL_DECRYPT_EN
        // Decrypt AES-256: rounds count down from 14 to 0.
        start_block(2'b10, 1'b1, 14, 0, 0, 1'b1);
        wait_done(11);
        Decrypt = 1'b0;
`endif

        repeat (3) tick();
        chk("pending_blocks", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
